cpu_eu: RTL

Execution unit of the 301 16-bit RISC processor, directly downstream of the control unit. Each cycle it consumes the control word (register addresses, mux selects, PC/IR/memory/register-file enables, ALU opcode) and feeds back the instruction register `IR` and the combinational ALU flags `N`, `Z`, `C`. It holds the program counter, the instruction register, the 8x16 register file and the ALU, and it drives the memory address and write-data buses.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/eu_alu.sv | 46 ++++
 rtl/cpu_eu.sv | 83 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 301 CPU: datapath widths and ALU opcodes,
// used by both the execution unit and the control unit that drives alu_op.
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int ADR_W  = 3;

   localparam logic [3:0] ALU_PASS_S = 4'b0000;
   localparam logic [3:0] ALU_PASS_R = 4'b0001;
   localparam logic [3:0] ALU_INC    = 4'b0010;
   localparam logic [3:0] ALU_DEC    = 4'b0011;
   localparam logic [3:0] ALU_ADD    = 4'b0100;
   localparam logic [3:0] ALU_SUB    = 4'b0101;
   localparam logic [3:0] ALU_SHR    = 4'b0110;
   localparam logic [3:0] ALU_SHL    = 4'b0111;
   localparam logic [3:0] ALU_AND    = 4'b1000;
   localparam logic [3:0] ALU_OR     = 4'b1001;
   localparam logic [3:0] ALU_XOR    = 4'b1010;
   localparam logic [3:0] ALU_NOT    = 4'b1011;

endpackage

// File: rtl/eu_alu.sv
// Combinational ALU of the execution unit: result Y plus N/Z/C flags.
// Unused opcodes 1100-1111 pass S through with C cleared.
module eu_alu
   import cpu_pkg::*;
#(
   parameter int DW = DATA_W
) (
   input  logic [DW-1:0] r,
   input  logic [DW-1:0] s,
   input  logic [3:0]    alu_op,
   output logic [DW-1:0] y,
   output logic          n,
   output logic          z,
   output logic          c
);

   localparam logic [DW:0] ONE = {{DW{1'b0}}, 1'b1};

   logic [DW:0] res;

   // Bit DW of a 17-bit add is the carry; of a 17-bit subtract, the borrow.
   always_comb begin
      res = {1'b0, s};
      c   = 1'b0;
      case (alu_op)
         ALU_PASS_S: res = {1'b0, s};
         ALU_PASS_R: res = {1'b0, r};
         ALU_INC:    begin res = {1'b0, s} + ONE;        c = res[DW]; end
         ALU_DEC:    begin res = {1'b0, s} - ONE;        c = res[DW]; end
         ALU_ADD:    begin res = {1'b0, r} + {1'b0, s};  c = res[DW]; end
         ALU_SUB:    begin res = {1'b0, r} - {1'b0, s};  c = res[DW]; end
         ALU_SHR:    begin res = {2'b00, s[DW-1:1]};     c = s[0];    end
         ALU_SHL:    begin res = {1'b0, s[DW-2:0], 1'b0}; c = s[DW-1]; end
         ALU_AND:    res = {1'b0, r & s};
         ALU_OR:     res = {1'b0, r | s};
         ALU_XOR:    res = {1'b0, r ^ s};
         ALU_NOT:    res = {1'b0, ~s};
         default:    res = {1'b0, s};
      endcase
   end

   assign y = res[DW-1:0];
   assign n = y[DW-1];
   assign z = (y == '0);

endmodule

// File: rtl/cpu_eu.sv
// Execution unit of the 301 CPU: register file, PC, IR, ALU and memory buses.
// Define CPU_EU_DEBUG_PORT_EN to add a third register read port (dbg_sel/dbg_out).
module cpu_eu
   import cpu_pkg::*;
#(
   parameter int DW = DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ADR_W-1:0] W_Adr,
   input  logic [ADR_W-1:0] R_Adr,
   input  logic [ADR_W-1:0] S_Adr,
   input  logic             adr_sel,
   input  logic             s_sel,
   input  logic             pc_ld,
   input  logic             pc_inc,
   input  logic             pc_sel,
   input  logic             ir_ld,
   input  logic             rw_en,
   input  logic [3:0]       alu_op,
   input  logic [DW-1:0]    D_in,
   output logic [DW-1:0]    IR,
   output logic             N,
   output logic             Z,
   output logic             C,
   output logic [DW-1:0]    Address,
`ifdef CPU_EU_DEBUG_PORT_EN
   output logic [DW-1:0]    D_out,
   input  logic [ADR_W-1:0] dbg_sel,
   output logic [DW-1:0]    dbg_out
`else
   output logic [DW-1:0]    D_out
`endif
);

   logic [DW-1:0] regs [2**ADR_W];
   logic [DW-1:0] pc;
   logic [DW-1:0] ir_q;
   logic [DW-1:0] r_out;
   logic [DW-1:0] s_out;
   logic [DW-1:0] alu_y;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] br_off;

   assign r_out = regs[R_Adr];
   assign s_out = regs[S_Adr];

   eu_alu #(.DW(DW)) u_alu (
      .r      (r_out),
      .s      (s_out),
      .alu_op (alu_op),
      .y      (alu_y),
      .n      (N),
      .z      (Z),
      .c      (C)
   );

   assign wr_data = s_sel ? D_in : alu_y;
   // Relative branch offset is the signed low byte of the current IR.
   assign br_off  = {{(DW-8){ir_q[7]}}, ir_q[7:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc   <= '0;
         ir_q <= '0;
         for (int i = 0; i < 2**ADR_W; i++) regs[i] <= '0;
      end else begin
         if (pc_ld)       pc <= pc_sel ? s_out : pc + br_off;
         else if (pc_inc) pc <= pc + 1'b1;
         if (ir_ld)       ir_q <= D_in;
         if (rw_en)       regs[W_Adr] <= wr_data;
      end
   end

   assign IR      = ir_q;
   assign Address = adr_sel ? r_out : pc;
   assign D_out   = s_out;

`ifdef CPU_EU_DEBUG_PORT_EN
   assign dbg_out = regs[dbg_sel];
`endif

endmodule
